// File: rtl/risc_pkg.sv
`default_nettype none
// ---- risc_pkg : shared opcodes, bubble encoding and IF/ID stage states ---- rev 1.0

package risc_pkg;

   localparam logic [3:0]  OP_LM  = 4'b0110;
   localparam logic [3:0]  OP_SM  = 4'b0111;
   localparam logic [15:0] NOP_IR = 16'hF000;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } stage_state_t;

   function automatic logic is_lmsm(input logic [15:0] ir);
      return (ir[15:12] == OP_LM) || (ir[15:12] == OP_SM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe1_lmsm_seq_if.sv
`default_nettype none
// ---- pipe1_lmsm_seq_if : fetch-side inputs and decode-side outputs of the IF/ID stage ---- rev 1.0

interface pipe1_lmsm_seq_if;

   logic [15:0] if_pc;
   logic [15:0] if_ir;
   logic        if_valid;
   logic        stall;
   logic        flush;
   logic [15:0] id_pc;
   logic [15:0] id_ir;
   logic        id_valid;
   logic        fetch_hold;
   logic [2:0]  lmsm_offset;

   modport master (
      output if_pc, if_ir, if_valid, stall, flush,
      input  id_pc, id_ir, id_valid, fetch_hold, lmsm_offset
   );

   modport slave (
      input  if_pc, if_ir, if_valid, stall, flush,
      output id_pc, id_ir, id_valid, fetch_hold, lmsm_offset
   );

endinterface

`default_nettype wire

// File: rtl/pipe1_lmsm_seq_lsb_clear8.sv
`default_nettype none
// ---- lsb_clear8 : clears the lowest set bit of an 8-bit mask and classifies its population ---- rev 1.0

module lsb_clear8 (
   input  logic [7:0] mask,
   output logic [7:0] cleared,
   output logic       multi,
   output logic       one
);

   assign cleared = mask & (mask - 8'd1);
   // A nonzero remainder means at least two bits were set.
   assign multi   = (cleared != 8'd0);
   assign one     = (mask != 8'd0) && (cleared == 8'd0);

endmodule

`default_nettype wire

// File: rtl/pipe1_lmsm_seq.sv
`default_nettype none
// ---- pipe1_lmsm_seq : IF/ID pipeline register that expands LM/SM into one slot per mask bit ----
// ---- sequencing enabled by macro LMSM_SEQ_EN ---- rev 1.0

module pipe1_lmsm_seq
   import risc_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   pipe1_lmsm_seq_if.slave bus
);

`ifdef LMSM_SEQ_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   stage_state_t state;

   logic [7:0] sel_mask;
   logic [7:0] cur_cleared;
   logic [7:0] nxt_cleared;
   logic       cur_multi;
   logic       cur_one;
   logic       nxt_multi;
   logic       nxt_one;
   logic       to_multi;
   logic       unused_flags;

   // One classifier serves both the capture decision and the per-step mask update.
   assign sel_mask = (state == MULTI) ? bus.id_ir[7:0] : bus.if_ir[7:0];

   lsb_clear8 u_cur (
      .mask    (sel_mask),
      .cleared (cur_cleared),
      .multi   (cur_multi),
      .one     (cur_one)
   );

   lsb_clear8 u_nxt (
      .mask    (cur_cleared),
      .cleared (nxt_cleared),
      .multi   (nxt_multi),
      .one     (nxt_one)
   );

   assign to_multi     = SEQ_EN && bus.if_valid && is_lmsm(bus.if_ir) && cur_multi;
   assign unused_flags = ^{cur_one, nxt_multi, nxt_cleared};

`ifdef LMSM_SEQ_EN
   assign bus.fetch_hold = (state == MULTI);
`else
   assign bus.fetch_hold = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.id_pc       <= 16'h0000;
         bus.id_ir       <= NOP_IR;
         bus.id_valid    <= 1'b0;
         bus.lmsm_offset <= 3'd0;
         state           <= EMPTY;
      end else if (bus.flush) begin
         bus.id_ir       <= NOP_IR;
         bus.id_valid    <= 1'b0;
         bus.lmsm_offset <= 3'd0;
         state           <= EMPTY;
      end else if (!bus.stall) begin
         if (state == MULTI) begin
            bus.id_ir[7:0]  <= cur_cleared;
            bus.lmsm_offset <= bus.lmsm_offset + 3'd1;
            state           <= nxt_one ? SINGLE : MULTI;
         end else begin
            bus.id_pc       <= bus.if_pc;
            bus.id_ir       <= bus.if_ir;
            bus.id_valid    <= bus.if_valid;
            bus.lmsm_offset <= 3'd0;
            if (to_multi)
               state <= MULTI;
            else if (bus.if_valid)
               state <= SINGLE;
            else
               state <= EMPTY;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe1_lmsm_seq.sv
`default_nettype none
// ---- tb_pipe1_lmsm_seq : directed table, hand sequences and randomized model check ---- rev 1.0

module tb_pipe1_lmsm_seq;
   import risc_pkg::*;

`ifdef LMSM_SEQ_EN
   localparam bit SEQ = 1'b1;
`else
   localparam bit SEQ = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   pipe1_lmsm_seq_if bus ();

   pipe1_lmsm_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       nm;
      logic        st;
      logic        fl;
      logic        v;
      logic [15:0] pc;
      logic [15:0] ir;
      logic [15:0] epc;
      logic [15:0] eir;
      logic        ev;
      logic        eh;
      logic [2:0]  eoff;
   } vec_t;

   vec_t tbl [11];

   // Reference model: the stage as seen from outside, one slot per transfer.
   logic [15:0] m_pc, m_ir;
   logic        m_v;
   logic [2:0]  m_off;

   function automatic logic m_hold();
      return SEQ && m_v && is_lmsm(m_ir) && ($countones(m_ir[7:0]) >= 2);
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_ir = NOP_IR; m_v = 1'b0; m_off = 3'd0;
   endtask

   task automatic model_step(input logic st, fl, v, input logic [15:0] pc, ir);
      if (fl) begin
         m_ir = NOP_IR; m_v = 1'b0; m_off = 3'd0;
      end else if (!st) begin
         if (m_hold()) begin
            for (int b = 0; b < 8; b++) begin
               if (m_ir[b]) begin
                  m_ir[b] = 1'b0;
                  break;
               end
            end
            m_off = m_off + 3'd1;
         end else begin
            m_pc = pc; m_ir = ir; m_v = v; m_off = 3'd0;
         end
      end
   endtask

   task automatic check(input string nm, input logic [15:0] pc, ir,
                        input logic v, h, input logic [2:0] off);
      total++;
      if ({bus.id_pc, bus.id_ir, bus.id_valid, bus.fetch_hold, bus.lmsm_offset}
          !== {pc, ir, v, h, off}) begin
         bad++;
         $display("FAIL %s: got pc=%h ir=%h valid=%b hold=%b off=%0d, want pc=%h ir=%h valid=%b hold=%b off=%0d",
                  nm, bus.id_pc, bus.id_ir, bus.id_valid, bus.fetch_hold, bus.lmsm_offset,
                  pc, ir, v, h, off);
      end
   endtask

   task automatic apply(input logic st, fl, v, input logic [15:0] pc, ir);
      bus.stall = st; bus.flush = fl; bus.if_valid = v; bus.if_pc = pc; bus.if_ir = ir;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp_ir;
      logic [7:0]  ff;

      tbl[0]  = '{"add",        0, 0, 1, 16'h0010, 16'h0298, 16'h0010, 16'h0298, 1, 0, 3'd0};
      tbl[1]  = '{"lm0b_c0",    0, 0, 1, 16'h0020, 16'h600B, 16'h0020, 16'h600B, 1, SEQ, 3'd0};
      tbl[2]  = '{"lm0b_c1",    0, 0, 1, 16'h0022, 16'h1111,
                  SEQ ? 16'h0020 : 16'h0022, SEQ ? 16'h600A : 16'h1111, 1, SEQ, SEQ ? 3'd1 : 3'd0};
      tbl[3]  = '{"lm0b_c2",    0, 0, 1, 16'h0022, 16'h1111,
                  SEQ ? 16'h0020 : 16'h0022, SEQ ? 16'h6008 : 16'h1111, 1, 0, SEQ ? 3'd2 : 3'd0};
      tbl[4]  = '{"lm0b_next",  0, 0, 1, 16'h0022, 16'h1111, 16'h0022, 16'h1111, 1, 0, 3'd0};
      tbl[5]  = '{"sm_onebit",  0, 0, 1, 16'h0030, 16'h7080, 16'h0030, 16'h7080, 1, 0, 3'd0};
      tbl[6]  = '{"sm_zero",    0, 0, 1, 16'h0032, 16'h7000, 16'h0032, 16'h7000, 1, 0, 3'd0};
      tbl[7]  = '{"lm07_c0",    0, 0, 1, 16'h0040, 16'h6007, 16'h0040, 16'h6007, 1, SEQ, 3'd0};
      tbl[8]  = '{"flush_stall",1, 1, 1, 16'h0042, 16'h5555, 16'h0040, 16'hF000, 0, 0, 3'd0};
      tbl[9]  = '{"invalid",    0, 0, 0, 16'h0050, 16'h2222, 16'h0050, 16'h2222, 0, 0, 3'd0};
      tbl[10] = '{"stall_empty",1, 0, 1, 16'h0060, 16'h3333, 16'h0050, 16'h2222, 0, 0, 3'd0};

      reset_n = 1'b1;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.if_valid = 1'b0;
      bus.if_pc = 16'h0000; bus.if_ir = 16'h0000;
      #1 reset_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("reset", 16'h0000, NOP_IR, 1'b0, 1'b0, 3'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         apply(tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].pc, tbl[i].ir);
         check(tbl[i].nm, tbl[i].epc, tbl[i].eir, tbl[i].ev, tbl[i].eh, tbl[i].eoff);
      end

      // LM with full mask, stalled on its second slot.
      apply(0, 0, 1, 16'h0070, 16'h60FF);
      check("lmff_c0", 16'h0070, 16'h60FF, 1'b1, SEQ, 3'd0);
      apply(0, 0, 1, 16'h0072, 16'h1111);
      check("lmff_c1", SEQ ? 16'h0070 : 16'h0072, SEQ ? 16'h60FE : 16'h1111, 1'b1, SEQ,
            SEQ ? 3'd1 : 3'd0);
      apply(1, 0, 1, 16'h0072, 16'h1111);
      check("lmff_stall", SEQ ? 16'h0070 : 16'h0072, SEQ ? 16'h60FE : 16'h1111, 1'b1, SEQ,
            SEQ ? 3'd1 : 3'd0);
      for (int k = 2; k < 8; k++) begin
         ff     = 8'hFF << k;
         exp_ir = SEQ ? {8'h60, ff} : 16'h1111;
         apply(0, 0, 1, 16'h0072, 16'h1111);
         check($sformatf("lmff_c%0d", k), SEQ ? 16'h0070 : 16'h0072, exp_ir, 1'b1,
               SEQ && (k < 7), SEQ ? 3'(k) : 3'd0);
      end
      apply(0, 0, 1, 16'h0072, 16'h1111);
      check("lmff_next", 16'h0072, 16'h1111, 1'b1, 1'b0, 3'd0);

      // Asynchronous reset in the middle of a sequence, no clock edge involved.
      apply(0, 0, 1, 16'h0080, 16'h600B);
      check("lm_pre_rst", 16'h0080, 16'h600B, 1'b1, SEQ, 3'd0);
      bus.if_valid = 1'b0;
      reset_n = 1'b0;
      #2;
      check("rst_async", 16'h0000, NOP_IR, 1'b0, 1'b0, 3'd0);
      reset_n = 1'b1;
      model_reset();

      for (int n = 0; n < 600; n++) begin
         logic        st, fl, v;
         logic [15:0] pc, ir;
         st = ($urandom_range(0, 6) == 0);
         fl = ($urandom_range(0, 11) == 0);
         v  = ($urandom_range(0, 4) != 0);
         pc = 16'($urandom);
         ir = 16'($urandom);
         if ($urandom_range(0, 1) == 1)
            ir[15:12] = $urandom_range(0, 1) == 1 ? OP_LM : OP_SM;
         apply(st, fl, v, pc, ir);
         model_step(st, fl, v, pc, ir);
         check("rand", m_pc, m_ir, m_v, m_hold(), m_off);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe1_lmsm_seq.md
PIPE1_LMSM_SEQ -- requirements
Module: pipe1_lmsm_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports:
  - clk  input  1  rising-edge clock
  - reset_n  input  1  asynchronous active-low reset
  - if_pc  input  16  PC of the fetched instruction
  - if_ir  input  16  fetched instruction word
  - if_valid  input  1  fetch output is a real instruction
  - stall  input  1  hazard unit freezes this stage
  - flush  input  1  taken branch/jump kills this stage
  - id_pc  output  16  registered PC to decode (fromPipe1PC)
  - id_ir  output  16  registered, possibly modified, IR to decode
  - id_valid  output  1  id_ir is a live instruction
  - fetch_hold  output  1  fetch shall keep PC and present the same if_* next cycle
  - lmsm_offset  output  3  index of the current LM/SM transfer, 0..7
REQ-002 No parameters; all widths SHALL be fixed as listed.

Function
REQ-003 The stage SHALL have three states:
  - EMPTY: id_valid=0.
  - SINGLE: valid, no further sub-operations pending.
  - MULTI: valid LM/SM with two or more mask bits set in id_ir[7:0].
REQ-004 An LM/SM instruction SHALL be identified by id_ir[15:12] equal to 4'b0110 (LM) or 4'b0111 (SM).
REQ-005 fetch_hold SHALL be 1 exactly when state is MULTI; it SHALL be decoded from registered state only, with no input-to-output path.
REQ-006 In EMPTY or SINGLE, with stall=0 and flush=0, each clock edge SHALL capture:
  - id_pc<=if_pc, id_ir<=if_ir, id_valid<=if_valid, lmsm_offset<=0.
  - Next state: MULTI if if_valid, the opcode is LM/SM and if_ir[7:0] has two or more bits set; SINGLE if if_valid otherwise; else EMPTY.
REQ-007 In MULTI, with stall=0 and flush=0, each edge SHALL:
  - clear the lowest set bit of id_ir[7:0];
  - hold id_ir[15:8] and id_pc;
  - increment lmsm_offset by 1;
  - ignore if_* inputs.
REQ-008 From MULTI, the next state SHALL be SINGLE when the cleared mask has exactly one bit set, else MULTI.
REQ-009 An LM/SM with mask 0 or exactly one bit SHALL pass as SINGLE for one cycle, with fetch_hold=0.
REQ-010 stall=1 SHALL freeze all registers and state, including lmsm_offset; fetch_hold keeps its value.
REQ-011 flush=1 SHALL take priority over stall and sequencing. On the next edge:
  - id_ir<=16'hF000 (bubble), id_valid<=0, lmsm_offset<=0, state<=EMPTY.
  - id_pc is unchanged.
  - Any MULTI sequence is aborted.
REQ-012 Latency SHALL be one cycle from if_* to id_*. An LM/SM with N set mask bits (N>=1) SHALL occupy the stage for N unstalled cycles.
REQ-013 lmsm_offset SHALL count transfers in issue order; it cannot wrap because at most 8 bits can be set.

Reset
REQ-014 Assertion of reset_n=0 SHALL immediately set:
  - id_pc=0, id_ir=16'hF000, id_valid=0;
  - lmsm_offset=0, state=EMPTY, fetch_hold=0.
REQ-015 Reset mid-sequence SHALL abandon the LM/SM; no partial state survives deassertion.

Configuration
REQ-016 Macro LMSM_SEQ_EN SHALL control sequencing:
  - Defined: behaviour per REQ-003..REQ-013.
  - Undefined: the MULTI state does not exist, fetch_hold and lmsm_offset are constant 0, and LM/SM pass through once, like any instruction. Flush, stall and reset behaviour is unchanged.

Structure
REQ-017 The shared package risc_pkg SHALL hold:
  - OP_LM=4'b0110, OP_SM=4'b0111;
  - NOP_IR=16'hF000;
  - the state enumeration {EMPTY, SINGLE, MULTI}.
REQ-018 One combinational sub-module, lsb_clear8, SHALL be used. It takes an 8-bit mask and outputs:
  - the mask with its lowest set bit cleared;
  - a flag for two or more bits set;
  - a flag for exactly one bit set.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - ADD 16'h0298 at pc 16'h0010, valid: next cycle id_ir=16'h0298, id_pc=16'h0010, id_valid=1, fetch_hold=0.
  - LM 16'h600B at pc 16'h0020: id_ir successively 16'h600B, 16'h600A, 16'h6008 with offset 0,1,2 and fetch_hold 1,1,0; the next instruction is captured on cycle 4.
  - SM 16'h7080 (single bit): one cycle, fetch_hold=0, offset=0. SM 16'h7000 (mask 0): one cycle, id_valid=1.
  - LM 16'h60FF with stall=1 on the second cycle: id_ir=16'h60FE and offset=1 held for the stalled cycle; the sequence completes after 8 unstalled cycles.
  - LM 16'h6007 with flush=1 in the second cycle, stall=1 asserted simultaneously: next cycle id_ir=16'hF000, id_valid=0, fetch_hold=0, offset=0.
  - reset_n pulsed low mid-MULTI without a clock edge: outputs go to reset values immediately. With LMSM_SEQ_EN undefined, LM 16'h600B gives fetch_hold=0 and a single cycle.
